// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU core: req/ack instruction fetch, register file,
// bounded return stack, zero/carry branches, halt and stack-fault reporting.
module acc_cpu_core #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NREGS       = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [DATA_W+3:0]        imem_rdata,
  input  logic                     imem_ack,
  input  logic [$clog2(NREGS)-1:0] dbg_reg_addr,
  output logic [DATA_W-1:0]        dbg_reg_data,
  output logic [DATA_W-1:0]        acc,
  output logic                     cy,
  output logic [ADDR_W-1:0]        pc,
  output logic                     halted,
  output logic                     fault
);

  localparam int unsigned RW  = $clog2(NREGS);
  localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_e;
  typedef enum logic [3:0] {
    OP_NOP, OP_LDI, OP_LD, OP_ST, OP_ADD, OP_ADDI, OP_SUB, OP_AND,
    OP_OR, OP_XOR, OP_JMP, OP_JC, OP_JZ, OP_CALL, OP_RET, OP_HLT
  } op_e;

  state_e              state_q, state_d;
  logic [DATA_W+3:0]   ir_q, ir_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                cy_q, cy_d;
  logic                halted_q, halted_d;
  logic                fault_q, fault_d;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   regs_d [NREGS];
  logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0]   stack_d [STACK_DEPTH];
  logic [SPW-1:0]      sp_q, sp_d;

  op_e                 op;
  logic [DATA_W-1:0]   arg, rval, addend;
  logic [RW-1:0]       ridx;
  logic [ADDR_W-1:0]   tgt, pc_inc;
  logic [DATA_W:0]     sum;
  logic [SPW-1:0]      sp_dec;
  logic [SIW-1:0]      push_idx, pop_idx;

  assign op       = op_e'(ir_q[DATA_W+3:DATA_W]);
  assign arg      = ir_q[DATA_W-1:0];
  assign ridx     = arg[RW-1:0];
  assign tgt      = arg[ADDR_W-1:0];
  assign rval     = regs_q[ridx];
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign addend   = (op == OP_ADDI) ? arg : rval;
  assign sum      = {1'b0, acc_q} + {1'b0, addend};
  // sp is one bit wider than the stack index so "full" is representable
  assign sp_dec   = sp_q - SPW'(1);
  assign push_idx = sp_q[SIW-1:0];
  assign pop_idx  = sp_dec[SIW-1:0];

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    cy_d     = cy_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    regs_d   = regs_q;
    stack_d  = stack_q;
    sp_d     = sp_q;
    imem_req = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (op)
          OP_LDI:  acc_d = arg;
          OP_LD:   acc_d = rval;
          OP_ST:   regs_d[ridx] = acc_q;
          OP_ADD,
          OP_ADDI: {cy_d, acc_d} = sum;
          OP_SUB: begin
            acc_d = acc_q - rval;
            cy_d  = (acc_q < rval);
          end
          OP_AND:  acc_d = acc_q & rval;
          OP_OR:   acc_d = acc_q | rval;
          OP_XOR:  acc_d = acc_q ^ rval;
          OP_JMP:  pc_d = tgt;
          OP_JC:   if (cy_q) pc_d = tgt;
          OP_JZ:   if (acc_q == '0) pc_d = tgt;
          OP_CALL: begin
            if (sp_q == SPW'(STACK_DEPTH)) begin
              pc_d     = pc_q;
              fault_d  = 1'b1;
              halted_d = 1'b1;
              state_d  = S_HALT;
            end else begin
              stack_d[push_idx] = pc_inc;
              sp_d              = sp_q + SPW'(1);
              pc_d              = tgt;
            end
          end
          OP_RET: begin
            if (sp_q == '0) begin
              pc_d     = pc_q;
              fault_d  = 1'b1;
              halted_d = 1'b1;
              state_d  = S_HALT;
            end else begin
              pc_d = stack_q[pop_idx];
              sp_d = sp_dec;
            end
          end
          OP_HLT: begin
            pc_d     = pc_q;
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          default: ;
        endcase
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      ir_q     <= '0;
      pc_q     <= '0;
      acc_q    <= '0;
      cy_q     <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      sp_q     <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      cy_q     <= cy_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      sp_q     <= sp_d;
      regs_q   <= regs_d;
      stack_q  <= stack_d;
    end
  end

  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign acc          = acc_q;
  assign cy           = cy_q;
  assign halted       = halted_q;
  assign fault        = fault_q;
  assign dbg_reg_data = regs_q[dbg_reg_addr];

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: drives the fetch handshake and compares against an
// instruction-level ISA model after every executed instruction.
module tb_acc_cpu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack = 1'b0;
  logic [7:0]  imem_addr;
  logic [11:0] imem_rdata = '0;
  logic [2:0]  dbg_reg_addr = '0;
  logic [7:0]  dbg_reg_data, acc, pc;
  logic        cy, halted, fault;

  acc_cpu_core #(.DATA_W(8), .NREGS(8), .ADDR_W(8), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .dbg_reg_addr(dbg_reg_addr),
    .dbg_reg_data(dbg_reg_data), .acc(acc), .cy(cy), .pc(pc),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  logic [11:0] prog [256];

  // ISA-level reference state
  int m_pc, m_acc, m_cy, m_halt, m_fault;
  int m_R [8];
  int m_stk [$];

  function automatic logic [11:0] ins(input int op, input int a);
    return {4'(op), 8'(a)};
  endfunction

  task automatic model_reset();
    m_pc = 0; m_acc = 0; m_cy = 0; m_halt = 0; m_fault = 0;
    for (int i = 0; i < 8; i++) m_R[i] = 0;
    m_stk.delete();
  endtask

  task automatic model_step(input logic [11:0] w);
    int op, a, r, s, nxt;
    op = int'(w[11:8]); a = int'(w[7:0]); r = a % 8; nxt = (m_pc + 1) % 256;
    case (op)
      1: m_acc = a;
      2: m_acc = m_R[r];
      3: m_R[r] = m_acc;
      4, 5: begin
        s = m_acc + ((op == 4) ? m_R[r] : a);
        m_cy = (s > 255); m_acc = s % 256;
      end
      6: begin m_cy = (m_acc < m_R[r]); m_acc = (m_acc - m_R[r] + 256) % 256; end
      7: m_acc = m_acc & m_R[r];
      8: m_acc = m_acc | m_R[r];
      9: m_acc = m_acc ^ m_R[r];
      10: nxt = a;
      11: if (m_cy != 0) nxt = a;
      12: if (m_acc == 0) nxt = a;
      13: if (m_stk.size() == 4) begin m_fault = 1; m_halt = 1; nxt = m_pc; end
          else begin m_stk.push_back(nxt); nxt = a; end
      14: if (m_stk.size() == 0) begin m_fault = 1; m_halt = 1; nxt = m_pc; end
          else nxt = m_stk.pop_back();
      15: begin m_halt = 1; nxt = m_pc; end
      default: ;
    endcase
    m_pc = nxt;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    imem_ack = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // One instruction: lat FETCH wait cycles, then ack; optional ack noise in EXEC.
  task automatic exec_one(input int lat, input bit noise);
    logic [11:0] w;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      imem_ack = 1'b0; imem_rdata = 12'($urandom);
      n_chk++;
      if (imem_req !== 1'b1 || imem_addr !== 8'(m_pc) || pc !== 8'(m_pc) || acc !== 8'(m_acc)) begin
        n_fail++;
        $display("FAIL fetch_wait: req=%b addr=%h pc=%h acc=%h exp req=1 addr/pc=%h acc=%h",
                 imem_req, imem_addr, pc, acc, 8'(m_pc), 8'(m_acc));
      end
    end
    @(negedge clk);
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 8'(m_pc)) begin
      n_fail++;
      $display("FAIL fetch_req: req=%b addr=%h exp 1 %h", imem_req, imem_addr, 8'(m_pc));
    end
    w = prog[8'(m_pc)];
    imem_ack = 1'b1; imem_rdata = w;
    @(negedge clk);
    n_chk++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL exec_req: req=%b exp 0", imem_req);
    end
    imem_ack = noise; imem_rdata = 12'($urandom);
    dbg_reg_addr = (w[11:8] == 4'd3) ? w[2:0] : 3'($urandom);
    @(posedge clk);
    #1;
    model_step(w);
    n_chk++;
    if (pc !== 8'(m_pc) || acc !== 8'(m_acc) || cy !== 1'(m_cy) ||
        halted !== 1'(m_halt) || fault !== 1'(m_fault)) begin
      n_fail++;
      $display("FAIL arch_state ins=%h: pc=%h acc=%h cy=%b h=%b f=%b exp pc=%h acc=%h cy=%b h=%b f=%b",
               w, pc, acc, cy, halted, fault, 8'(m_pc), 8'(m_acc), 1'(m_cy), 1'(m_halt), 1'(m_fault));
    end
    n_chk++;
    if (dbg_reg_data !== 8'(m_R[dbg_reg_addr]) || imem_req !== 1'(!m_halt)) begin
      n_fail++;
      $display("FAIL dbg_or_req: R[%0d]=%h req=%b exp %h %b", dbg_reg_addr, dbg_reg_data,
               imem_req, 8'(m_R[dbg_reg_addr]), 1'(!m_halt));
    end
  endtask

  task automatic check_hold(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      imem_ack = 1'($urandom); imem_rdata = 12'($urandom);
      n_chk++;
      if (imem_req !== 1'b0 || pc !== 8'(m_pc) || acc !== 8'(m_acc) || halted !== 1'b1 ||
          fault !== 1'(m_fault)) begin
        n_fail++;
        $display("FAIL halt_hold: req=%b pc=%h acc=%h h=%b f=%b exp 0 %h %h 1 %b",
                 imem_req, pc, acc, halted, fault, 8'(m_pc), 8'(m_acc), 1'(m_fault));
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    clear_prog();
    prog[0] = ins(1, 8'hF0); prog[1] = ins(5, 8'h20);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    n_chk++;
    if (pc !== 8'h00 || acc !== 8'h00 || cy !== 1'b0 || halted !== 1'b0 || fault !== 1'b0 ||
        imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h acc=%h cy=%b h=%b f=%b req=%b addr=%h exp zeros req=1",
               pc, acc, cy, halted, fault, imem_req, imem_addr);
    end
    for (int i = 0; i < 8; i++) begin
      dbg_reg_addr = 3'(i);
      #1;
      n_chk++;
      if (dbg_reg_data !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h exp 00", i, dbg_reg_data);
      end
    end
    exec_one(0, 1'b0);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = prog[1];
    @(negedge clk);
    imem_ack = 1'b1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; imem_ack = 1'b0;
    model_reset();
    n_chk++;
    if (pc !== 8'h00 || acc !== 8'h00 || cy !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_exec: pc=%h acc=%h cy=%b h=%b req=%b exp 00 00 0 0 1",
               pc, acc, cy, halted, imem_req);
    end
  endtask

  task automatic test_basic();
    int c0;
    do_reset();
    clear_prog();
    prog[0] = ins(1, 8'hF0); prog[1] = ins(5, 8'h20);
    c0 = cyc;
    exec_one(0, 1'b0);
    exec_one(0, 1'b1);
    n_chk++;
    if (acc !== 8'h10 || cy !== 1'b1 || pc !== 8'h02 || (cyc - c0) != 4) begin
      n_fail++;
      $display("FAIL basic_addi: acc=%h cy=%b pc=%h cycles=%0d exp 10 1 02 4", acc, cy, pc, cyc - c0);
    end
  endtask

  task automatic test_delay();
    do_reset();
    clear_prog();
    prog[0] = ins(1, 8'h33); prog[1] = ins(3, 2); prog[2] = ins(2, 2);
    exec_one(3, 1'b1);
    exec_one(3, 1'b0);
    exec_one(0, 1'b1);
    n_chk++;
    if (acc !== 8'h33 || pc !== 8'h03) begin
      n_fail++;
      $display("FAIL delayed_ack: acc=%h pc=%h exp 33 03", acc, pc);
    end
  endtask

  task automatic test_sub_branch();
    do_reset();
    clear_prog();
    prog[0] = ins(1, 7); prog[1] = ins(3, 1); prog[2] = ins(1, 5);
    prog[3] = ins(6, 1); prog[4] = ins(11, 8'h20); prog[8'h20] = ins(12, 8'h40);
    for (int i = 0; i < 4; i++) exec_one(1, 1'b1);
    n_chk++;
    if (acc !== 8'hFE || cy !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_borrow: acc=%h cy=%b exp FE 1", acc, cy);
    end
    exec_one(0, 1'b0);
    n_chk++;
    if (pc !== 8'h20) begin n_fail++; $display("FAIL jc_taken: pc=%h exp 20", pc); end
    exec_one(0, 1'b0);
    n_chk++;
    if (pc !== 8'h21) begin n_fail++; $display("FAIL jz_not_taken: pc=%h exp 21", pc); end
  endtask

  task automatic test_stack();
    do_reset();
    clear_prog();
    prog[0] = ins(13, 8'h10); prog[8'h10] = ins(13, 8'h20);
    prog[8'h20] = ins(13, 8'h30); prog[8'h30] = ins(13, 8'h40);
    prog[8'h40] = ins(14, 0); prog[8'h31] = ins(14, 0); prog[8'h21] = ins(14, 0);
    prog[8'h11] = ins(14, 0); prog[8'h01] = ins(14, 0);
    for (int i = 0; i < 4; i++) exec_one(0, 1'b1);
    n_chk++;
    if (pc !== 8'h40 || fault !== 1'b0) begin
      n_fail++; $display("FAIL call_depth4: pc=%h f=%b exp 40 0", pc, fault);
    end
    for (int i = 0; i < 4; i++) exec_one(0, 1'b0);
    n_chk++;
    if (pc !== 8'h01) begin n_fail++; $display("FAIL ret_chain: pc=%h exp 01", pc); end
    exec_one(0, 1'b0);
    n_chk++;
    if (fault !== 1'b1 || halted !== 1'b1 || pc !== 8'h01) begin
      n_fail++; $display("FAIL ret_underflow: f=%b h=%b pc=%h exp 1 1 01", fault, halted, pc);
    end
    check_hold(3);
    do_reset();
    prog[8'h40] = ins(13, 8'h50);
    for (int i = 0; i < 5; i++) exec_one(0, 1'b0);
    n_chk++;
    if (fault !== 1'b1 || halted !== 1'b1 || pc !== 8'h40) begin
      n_fail++; $display("FAIL call_overflow: f=%b h=%b pc=%h exp 1 1 40", fault, halted, pc);
    end
    check_hold(3);
  endtask

  task automatic test_wrap_halt();
    do_reset();
    clear_prog();
    prog[0] = ins(12, 8'h10); prog[8'h10] = ins(1, 8'h5A); prog[8'h11] = ins(3, 3);
    prog[8'h12] = ins(10, 8'hFF); prog[8'hFF] = ins(0, 0); prog[1] = ins(15, 0);
    for (int i = 0; i < 5; i++) exec_one(0, 1'b0);
    n_chk++;
    if (pc !== 8'h00) begin n_fail++; $display("FAIL pc_wrap: pc=%h exp 00", pc); end
    dbg_reg_addr = 3'd3;
    #1;
    n_chk++;
    if (dbg_reg_data !== 8'h5A) begin n_fail++; $display("FAIL dbg_r3: got %h exp 5A", dbg_reg_data); end
    exec_one(0, 1'b0);
    exec_one(0, 1'b1);
    n_chk++;
    if (halted !== 1'b1 || fault !== 1'b0 || pc !== 8'h01) begin
      n_fail++; $display("FAIL hlt: h=%b f=%b pc=%h exp 1 0 01", halted, fault, pc);
    end
    check_hold(4);
  endtask

  task automatic test_random();
    int op, n;
    for (int round = 0; round < 15; round++) begin
      do_reset();
      for (int i = 0; i < 256; i++) begin
        op = $urandom_range(0, 15);
        if (op == 15 && $urandom_range(0, 7) != 0) op = 0;
        prog[i] = ins(op, $urandom_range(0, 255));
      end
      n = 0;
      while (m_halt == 0 && n < 40) begin
        exec_one($urandom_range(0, 2), 1'($urandom));
        n++;
      end
      if (m_halt != 0) check_hold(2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay();
    test_sub_branch();
    test_stack();
    test_wrap_halt();
    test_random();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
